// File: rtl/fetch_pc_ifid.sv
// ----------------------------------------------------------------------------
// fetch_pc_ifid
//
// Fetch-stage control. Owns the program counter (a word index), drives the
// word address of a synchronous instruction memory, and re-aligns that
// memory's one-cycle-late read data into the IF/ID pipeline outputs.
// Handles decode stalls, flushes and taken branches from later stages.
//
// Parameters:
//   RESET_PC   word address fetched first after reset
//   NOP_INSTR  instruction presented while if_valid = 0
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   stall          in   hold PC and IF/ID contents
//   flush          in   squash the instruction arriving at IF/ID next edge
//   branch_taken   in   redirect fetch to branch_target (implies flush)
//   branch_target  in   [31:0] word address to fetch after a redirect
//   imem_addr      out  [31:0] word address to memory (equals pc_q)
//   imem_data      in   [31:0] registered memory read data
//   if_instr       out  [31:0] IF/ID instruction
//   if_pc          out  [31:0] word address of if_instr
//   if_npc         out  [31:0] if_pc + 1 (wraps)
//   if_valid       out  if_instr is a live instruction
// ----------------------------------------------------------------------------
module fetch_pc_ifid #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_npc,
    output logic        if_valid
);

    logic [31:0] pc_q,         pc_d;
    logic [31:0] if_pc_q,      if_pc_d;
    logic        if_valid_q,   if_valid_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;

    // Next-state selection; priority is branch, flush, stall, normal advance.
    always_comb begin
        pc_d         = pc_q;
        if_pc_d      = if_pc_q;
        if_valid_d   = if_valid_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;

        if (branch_taken) begin
            pc_d         = branch_target;
            if_pc_d      = pc_q;
            if_valid_d   = 1'b0;
            hold_valid_d = 1'b0;
            hold_instr_d = '0;
        end else if (flush) begin
            pc_d         = pc_q + 32'd1;
            if_pc_d      = pc_q;
            if_valid_d   = 1'b0;
            hold_valid_d = 1'b0;
            hold_instr_d = '0;
        end else if (stall) begin
            // The memory keeps re-reading MEM[pc_q] while stalled, which is
            // the instruction after if_pc; capture the live word once on the
            // first stalled edge and present it from the hold register.
            if (!hold_valid_q) begin
                hold_instr_d = imem_data;
                hold_valid_d = 1'b1;
            end
        end else begin
            // Copying pc_q into if_pc on every advancing edge keeps if_pc
            // aligned with the data the memory captures on the same edge.
            pc_d         = pc_q + 32'd1;
            if_pc_d      = pc_q;
            if_valid_d   = 1'b1;
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            if_pc_q      <= RESET_PC;
            if_valid_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_instr_q <= '0;
        end else begin
            pc_q         <= pc_d;
            if_pc_q      <= if_pc_d;
            if_valid_q   <= if_valid_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    assign imem_addr = pc_q;
    assign if_pc     = if_pc_q;
    assign if_npc    = if_pc_q + 32'd1;
    assign if_valid  = if_valid_q;

    always_comb begin
        if (!if_valid_q) begin
            if_instr = NOP_INSTR;
        end else if (hold_valid_q) begin
            if_instr = hold_instr_q;
        end else begin
            if_instr = imem_data;
        end
    end

endmodule

// File: tb/tb_fetch_pc_ifid.sv
// ----------------------------------------------------------------------------
// tb_fetch_pc_ifid
//
// Two instances share stimulus: one with RESET_PC = 0, one with
// RESET_PC = FFFF_FFFF (and a non-zero NOP) to exercise wrap-around.
// Each instance has its own synchronous memory. The reference model tracks
// only the fetch PC, the IF/ID PC and validity; the expected instruction is
// simply MEM[if_pc] when valid, NOP otherwise.
// ----------------------------------------------------------------------------
module tb_fetch_pc_ifid;

    localparam logic [31:0] RPC0 = 32'h0000_0000;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP0 = 32'h0000_0000;
    localparam logic [31:0] NOP1 = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;

    logic [31:0] addr0, data0, instr0, pc0, npc0;
    logic [31:0] addr1, data1, instr1, pc1, npc1;
    logic        valid0, valid1;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference state, index 0/1 per instance.
    logic [31:0] m_pc    [2];
    logic [31:0] m_ifpc  [2];
    logic        m_valid [2];

    always #5 clk = ~clk;

    fetch_pc_ifid #(.RESET_PC(RPC0), .NOP_INSTR(NOP0)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(addr0), .imem_data(data0), .if_instr(instr0),
        .if_pc(pc0), .if_npc(npc0), .if_valid(valid0)
    );

    fetch_pc_ifid #(.RESET_PC(RPC1), .NOP_INSTR(NOP1)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(addr1), .imem_data(data1), .if_instr(instr1),
        .if_pc(pc1), .if_npc(npc1), .if_valid(valid1)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h0023_00AA;
            32'd1:   return 32'h1065_4321;
            32'd2:   return 32'h0010_0022;
            32'd3:   return 32'h8C12_3456;
            32'd4:   return 32'h8F12_3456;
            32'd5:   return 32'hAD65_4321;
            32'd8:   return 32'h1201_2345;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
        endcase
    endfunction

    // Synchronous instruction memories: MEM[addr] captured each edge.
    always @(posedge clk) begin
        data0 <= mem_word(addr0);
        data1 <= mem_word(addr1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input int k, input logic [31:0] rpc);
        if (rst) begin
            m_pc[k] = rpc; m_ifpc[k] = rpc; m_valid[k] = 1'b0;
        end else if (branch_taken) begin
            m_ifpc[k] = m_pc[k]; m_pc[k] = branch_target; m_valid[k] = 1'b0;
        end else if (flush) begin
            m_ifpc[k] = m_pc[k]; m_pc[k] = m_pc[k] + 32'd1; m_valid[k] = 1'b0;
        end else if (!stall) begin
            m_ifpc[k] = m_pc[k]; m_pc[k] = m_pc[k] + 32'd1; m_valid[k] = 1'b1;
        end
    endtask

    task automatic check_model(input int k, input logic [31:0] nop);
        logic [31:0] a, ins, p, np;
        logic        v;
        if (k == 0) begin a = addr0; ins = instr0; p = pc0; np = npc0; v = valid0; end
        else        begin a = addr1; ins = instr1; p = pc1; np = npc1; v = valid1; end
        check_eq($sformatf("d%0d.imem_addr", k), a, m_pc[k]);
        check_eq($sformatf("d%0d.if_valid", k), {31'd0, v}, {31'd0, m_valid[k]});
        check_eq($sformatf("d%0d.if_pc", k), p, m_ifpc[k]);
        check_eq($sformatf("d%0d.if_npc", k), np, m_ifpc[k] + 32'd1);
        check_eq($sformatf("d%0d.if_instr", k), ins,
                 m_valid[k] ? mem_word(m_ifpc[k]) : nop);
    endtask

    // One clock: model follows the edge, then outputs are compared mid-cycle.
    task automatic step();
        @(posedge clk);
        model_edge(0, RPC0);
        model_edge(1, RPC1);
        @(negedge clk);
        check_model(0, NOP0);
        check_model(1, NOP1);
    endtask

    task automatic drive(input logic r, input logic s, input logic f,
                         input logic b, input logic [31:0] t);
        rst = r; stall = s; flush = f; branch_taken = b; branch_target = t;
    endtask

    initial begin
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        step();
        check_eq("rst.valid", {31'd0, valid0}, 32'd0);
        check_eq("rst.instr", instr0, 32'h0);
        check_eq("rst.npc", npc0, 32'd1);
        check_eq("wrap.rst.addr", addr1, 32'hFFFF_FFFF);
        check_eq("wrap.rst.npc", npc1, 32'h0);

        // Free run.
        drive(0, 0, 0, 0, 0);
        step();
        check_eq("run0.instr", instr0, 32'h0023_00AA);
        check_eq("wrap.second_addr", addr1, 32'h0);
        check_eq("wrap.if_pc", pc1, 32'hFFFF_FFFF);
        check_eq("wrap.if_npc", npc1, 32'h0);
        step();
        check_eq("run1.instr", instr0, 32'h1065_4321);

        // Stall three cycles while if_pc = 1.
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall.instr", instr0, 32'h1065_4321);
            check_eq("stall.addr", addr0, 32'd2);
        end
        drive(0, 0, 0, 0, 0);
        step();
        check_eq("release.instr", instr0, 32'h0010_0022);
        check_eq("release.pc", pc0, 32'd2);

        // Branch to 8 while if_pc = 2.
        drive(0, 0, 0, 1, 32'd8);
        step();
        check_eq("br.bubble", {31'd0, valid0}, 32'd0);
        drive(0, 0, 0, 0, 0);
        step();
        check_eq("br.instr", instr0, 32'h1201_2345);
        check_eq("br.npc", npc0, 32'd9);

        // Branch with concurrent stall: branch wins.
        drive(0, 1, 0, 1, 32'd5);
        step();
        check_eq("brstall.bubble", {31'd0, valid0}, 32'd0);
        drive(0, 0, 0, 0, 0);
        step();
        check_eq("brstall.instr", instr0, 32'hAD65_4321);

        // Get to if_pc = 3, then flush.
        drive(0, 0, 0, 1, 32'd3);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        check_eq("pre_flush.pc", pc0, 32'd3);
        drive(0, 0, 1, 0, 0);
        step();
        check_eq("flush.valid", {31'd0, valid0}, 32'd0);
        drive(0, 0, 0, 0, 0);
        step();
        check_eq("flush.pc", pc0, 32'd5);
        check_eq("flush.instr", instr0, 32'hAD65_4321);

        // Reset during a stall; hold must be cleared.
        drive(0, 1, 0, 0, 0);
        step();
        step();
        drive(1, 1, 0, 0, 0);
        step();
        check_eq("rst_stall.valid", {31'd0, valid0}, 32'd0);
        check_eq("rst_stall.addr", addr0, 32'd0);
        drive(0, 0, 0, 0, 0);
        step();
        check_eq("rst_stall.instr", instr0, 32'h0023_00AA);

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 20));
            drive(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) == 0),
                  tgt);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
